// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the catch-the-ball game (state encoding,
// screen size and default bar geometry used by the referee, bar renderer and
// ball generator).
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    localparam int BAR_Y_DEFAULT      = 440;
    localparam int BAR_W_DEFAULT      = 80;
    localparam int LIVES_INIT_DEFAULT = 3;

    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

    // Increment one BCD digit; carry_out is set when the digit rolls 9 -> 0.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit);
        logic [4:0] result;
        if (digit >= 4'd9) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/ball_catch_referee_if.sv
// ball_catch_referee_if: frame-rate signals between the game side (ball
// generator, bar position, start button) and the referee.
interface ball_catch_referee_if;

    logic        start;
    logic        frame_tick;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [10:0] radius;
    logic [9:0]  bar_x;

    logic        caught;
    logic        new_game;
    logic [15:0] score;
    logic [2:0]  lives;
    logic        game_over;
    logic [2:0]  speed_level;

    modport master (
        output start, frame_tick, ball_x, ball_y, radius, bar_x,
        input  caught, new_game, score, lives, game_over, speed_level
    );

    modport slave (
        input  start, frame_tick, ball_x, ball_y, radius, bar_x,
        output caught, new_game, score, lives, game_over, speed_level
    );

endinterface

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit BCD counter with enable and synchronous clear that
// holds at 9999 instead of rolling over.
module bcd_counter4
    import game_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] value
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Ripple a +1 through the digits unless cleared or already saturated.
    always_comb begin
        logic       carry;
        logic [4:0] step;
        count_d = count_q;
        carry   = 1'b1;
        step    = 5'd0;
        if (clear) begin
            count_d = 16'h0000;
        end else if (enable && (count_q != SCORE_MAX_BCD)) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    step               = bcd_digit_inc(count_q[4*i +: 4]);
                    count_d[4*i +: 4]  = step[3:0];
                    carry              = step[4];
                end
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign value = count_q;

endmodule

// File: rtl/ball_catch_referee.sv
// ball_catch_referee: per-frame catch/miss referee with BCD score, lives and
// the IDLE/PLAY/GAME_OVER state machine.
// Optional feature macro: REFEREE_SPEED_LEVEL_EN (speed level rises every
// 8 catches when defined, otherwise speed_level is tied to zero).
module ball_catch_referee
    import game_pkg::*;
#(
    parameter int BAR_Y      = BAR_Y_DEFAULT,
    parameter int BAR_W      = BAR_W_DEFAULT,
    parameter int LIVES_INIT = LIVES_INIT_DEFAULT
) (
    input logic                 clk_in,
    input logic                 reset,
    ball_catch_referee_if.slave bus
);

    game_state_t state_q;
    game_state_t state_d;
    logic        armed_q;
    logic        armed_d;
    logic [2:0]  lives_q;
    logic [2:0]  lives_d;
    logic        caught_q;
    logic        caught_d;
    logic        new_game_q;
    logic        new_game_d;
    logic        game_over_q;
    logic        start_prev_q;

    logic        start_rise;
    logic [11:0] bottom;
    logic [11:0] reach_right;
    logic [11:0] reach_left;
    logic        in_x;
    logic        at_bar;
    logic        score_clr;
    logic        score_inc;
    logic [15:0] score_value;

    // Widen everything to 12 bits so no sum can wrap.
    assign bottom      = {2'b00, bus.ball_y} + {1'b0, bus.radius};
    assign reach_right = {2'b00, bus.ball_x} + {1'b0, bus.radius};
    assign reach_left  = {2'b00, bus.bar_x} + 12'(BAR_W) + {1'b0, bus.radius};
    assign in_x        = (reach_right >= {2'b00, bus.bar_x}) &&
                         ({2'b00, bus.ball_x} < reach_left);
    assign at_bar      = (bottom >= 12'(BAR_Y));
    assign start_rise  = bus.start && !start_prev_q;

    // Next-state logic: game start, catch/miss decision and re-arm.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        lives_d    = lives_q;
        caught_d   = 1'b0;
        new_game_d = 1'b0;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    state_d    = PLAY;
                    armed_d    = 1'b1;
                    lives_d    = 3'(LIVES_INIT);
                    new_game_d = 1'b1;
                    score_clr  = 1'b1;
                end
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    if (!at_bar) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d = 1'b0;
                        if (in_x) begin
                            caught_d  = 1'b1;
                            score_inc = 1'b1;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            if (lives_q == 3'd1) begin
                                state_d = GAME_OVER;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset overrides any pending event.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            lives_q      <= 3'd0;
            caught_q     <= 1'b0;
            new_game_q   <= 1'b0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            lives_q      <= lives_d;
            caught_q     <= caught_d;
            new_game_q   <= new_game_d;
            game_over_q  <= (state_d == GAME_OVER);
            start_prev_q <= bus.start;
        end
    end

    bcd_counter4 u_score (
        .clk_in (clk_in),
        .reset  (reset),
        .clear  (score_clr),
        .enable (score_inc),
        .value  (score_value)
    );

`ifdef REFEREE_SPEED_LEVEL_EN
    logic [2:0] catch_cnt_q;
    logic [2:0] speed_q;

    // Every eighth catch bumps the difficulty, holding at level 7.
    always_ff @(posedge clk_in) begin
        if (reset || score_clr) begin
            catch_cnt_q <= 3'd0;
            speed_q     <= 3'd0;
        end else if (score_inc) begin
            catch_cnt_q <= catch_cnt_q + 3'd1;
            if ((catch_cnt_q == 3'd7) && (speed_q != 3'd7)) begin
                speed_q <= speed_q + 3'd1;
            end
        end
    end

    assign bus.speed_level = speed_q;
`else
    assign bus.speed_level = 3'd0;
`endif

    assign bus.caught    = caught_q;
    assign bus.new_game  = new_game_q;
    assign bus.score     = score_value;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_ball_catch_referee.sv
// tb_ball_catch_referee: directed scenarios plus randomized play, all checked
// every cycle against a behavioural game model.
module tb_ball_catch_referee;

    localparam int BAR_Y      = 440;
    localparam int BAR_W      = 80;
    localparam int LIVES_INIT = 3;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    ball_catch_referee_if bus ();

    ball_catch_referee #(
        .BAR_Y      (BAR_Y),
        .BAR_W      (BAR_W),
        .LIVES_INIT (LIVES_INIT)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    // Model state: phase 0 idle, 1 playing, 2 game over; score kept in decimal.
    int m_phase    = 0;
    int m_score    = 0;
    int m_lives    = 0;
    int m_catches  = 0;
    bit m_armed    = 1'b0;
    bit m_prev_start = 1'b0;
    bit m_caught   = 1'b0;
    bit m_new_game = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int exp_speed();
`ifdef REFEREE_SPEED_LEVEL_EN
        return (m_catches / 8 > 7) ? 7 : m_catches / 8;
`else
        return 0;
`endif
    endfunction

    function automatic int clamp10(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input bit s, input bit t, input int bx,
                                  input int by, input int rad, input int barx);
        bus.start      = s;
        bus.frame_tick = t;
        bus.ball_x     = 10'(bx);
        bus.ball_y     = 10'(by);
        bus.radius     = 11'(rad);
        bus.bar_x      = 10'(barx);
        @(negedge clk_in);
    endtask

    // Game rules applied once per clock to the inputs the DUT is sampling.
    always @(posedge clk_in) begin : model_step
        int bottom;
        bit rise;
        bit hit;
        m_caught   = 1'b0;
        m_new_game = 1'b0;
        if (reset) begin
            m_phase      = 0;
            m_score      = 0;
            m_lives      = 0;
            m_catches    = 0;
            m_armed      = 1'b0;
            m_prev_start = 1'b0;
        end else begin
            rise         = bus.start && !m_prev_start;
            m_prev_start = bus.start;
            if (m_phase != 1) begin
                if (rise) begin
                    m_phase    = 1;
                    m_lives    = LIVES_INIT;
                    m_score    = 0;
                    m_catches  = 0;
                    m_armed    = 1'b1;
                    m_new_game = 1'b1;
                end
            end else if (bus.frame_tick) begin
                bottom = int'(bus.ball_y) + int'(bus.radius);
                hit = (int'(bus.ball_x) + int'(bus.radius) >= int'(bus.bar_x)) &&
                      (int'(bus.ball_x) < int'(bus.bar_x) + BAR_W + int'(bus.radius));
                if (bottom < BAR_Y) begin
                    m_armed = 1'b1;
                end else if (m_armed) begin
                    m_armed = 1'b0;
                    if (hit) begin
                        m_caught = 1'b1;
                        m_catches++;
                        if (m_score < 9999) m_score++;
                    end else begin
                        m_lives--;
                        if (m_lives == 0) m_phase = 2;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_in) begin
        if (check_en) begin
            check_output("caught",      32'(bus.caught),      32'(m_caught));
            check_output("new_game",    32'(bus.new_game),    32'(m_new_game));
            check_output("score",       32'(bus.score),       32'(to_bcd(m_score)));
            check_output("lives",       32'(bus.lives),       32'(m_lives));
            check_output("game_over",   32'(bus.game_over),   32'(m_phase == 2));
            check_output("speed_level", 32'(bus.speed_level), 32'(exp_speed()));
        end
    end

    initial begin
        int ng_count;
        bus.start = 1'b0;
        bus.frame_tick = 1'b0;
        bus.ball_x = '0;
        bus.ball_y = '0;
        bus.radius = '0;
        bus.bar_x  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        check_en = 1'b1;
        check_output("reset_lives", 32'(bus.lives), 32'd0);
        check_output("reset_score", 32'(bus.score), 32'h0);
        check_output("reset_game_over", 32'(bus.game_over), 32'd0);
        reset = 1'b0;

        // Start the first game; holding start gives only one pulse.
        apply_stimulus(1, 0, 0, 0, 10, 200);
        check_output("start_new_game", 32'(bus.new_game), 32'd1);
        check_output("start_lives", 32'(bus.lives), 32'd3);
        check_output("start_score", 32'(bus.score), 32'h0);
        apply_stimulus(1, 0, 0, 0, 10, 200);
        check_output("start_held_no_pulse", 32'(bus.new_game), 32'd0);
        apply_stimulus(0, 0, 0, 0, 10, 200);

        // Catch at the bar's left edge, then no double count, then re-arm.
        apply_stimulus(0, 1, 190, 430, 10, 200);
        check_output("left_edge_caught", 32'(bus.caught), 32'd1);
        check_output("left_edge_score", 32'(bus.score), 32'h0001);
        apply_stimulus(0, 1, 190, 440, 10, 200);
        check_output("no_second_catch", 32'(bus.caught), 32'd0);
        apply_stimulus(0, 1, 190, 20, 10, 200);

        // Miss just past the right edge.
        apply_stimulus(0, 1, 290, 430, 10, 200);
        check_output("right_edge_miss_caught", 32'(bus.caught), 32'd0);
        check_output("right_edge_miss_lives", 32'(bus.lives), 32'd2);
        check_output("right_edge_miss_score", 32'(bus.score), 32'h0001);
        apply_stimulus(0, 1, 290, 20, 10, 200);
        apply_stimulus(0, 1, 290, 430, 10, 200);
        apply_stimulus(0, 1, 290, 20, 10, 200);
        apply_stimulus(0, 1, 290, 430, 10, 200);
        check_output("last_miss_lives", 32'(bus.lives), 32'd0);
        check_output("last_miss_game_over", 32'(bus.game_over), 32'd1);
        apply_stimulus(0, 1, 190, 20, 10, 200);
        apply_stimulus(0, 1, 190, 430, 10, 200);
        check_output("over_tick_no_catch", 32'(bus.caught), 32'd0);
        check_output("over_tick_lives", 32'(bus.lives), 32'd0);

        // Restart from game over.
        apply_stimulus(1, 0, 190, 20, 10, 200);
        check_output("restart_new_game", 32'(bus.new_game), 32'd1);
        check_output("restart_lives", 32'(bus.lives), 32'd3);
        check_output("restart_score", 32'(bus.score), 32'h0);
        check_output("restart_game_over", 32'(bus.game_over), 32'd0);
        apply_stimulus(0, 0, 190, 20, 10, 200);

        // Catch ten thousand balls to hit score saturation.
        for (int i = 0; i < 10000; i++) begin
            apply_stimulus(0, 1, 240, 430, 10, 200);
`ifdef REFEREE_SPEED_LEVEL_EN
            if (i == 7)  check_output("speed_after_8",  32'(bus.speed_level), 32'd1);
            if (i == 55) check_output("speed_after_56", 32'(bus.speed_level), 32'd7);
`endif
            if (i == 9998) check_output("score_9999", 32'(bus.score), 32'h9999);
            if (i == 9999) begin
                check_output("saturated_caught", 32'(bus.caught), 32'd1);
                check_output("saturated_score", 32'(bus.score), 32'h9999);
            end
            apply_stimulus(0, 1, 240, 20, 10, 200);
        end

        // Reset coinciding with a qualifying tick, then start held through release.
        reset = 1'b1;
        apply_stimulus(0, 1, 240, 430, 10, 200);
        check_output("reset_tick_caught", 32'(bus.caught), 32'd0);
        check_output("reset_tick_score", 32'(bus.score), 32'h0);
        check_output("reset_tick_lives", 32'(bus.lives), 32'd0);
        check_output("reset_tick_speed", 32'(bus.speed_level), 32'd0);
        apply_stimulus(1, 0, 240, 20, 10, 200);
        check_output("reset_held_no_new_game", 32'(bus.new_game), 32'd0);
        reset = 1'b0;
        ng_count = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 240, 20, 10, 200);
            ng_count += int'(bus.new_game);
        end
        check_output("held_start_one_new_game", 32'(ng_count), 32'd1);
        apply_stimulus(0, 0, 240, 20, 10, 200);

        // Randomized play around the collision boundaries.
        for (int n = 0; n < 4000; n++) begin
            int rad;
            int barx;
            int bx;
            int by;
            reset = ($urandom_range(0, 299) == 0);
            rad  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047))
                                                : int'($urandom_range(0, 24));
            barx = int'($urandom_range(0, 1023));
            case ($urandom_range(0, 2))
                0: bx = clamp10(barx - rad + int'($urandom_range(0, 6)) - 3);
                1: bx = clamp10(barx + BAR_W + rad + int'($urandom_range(0, 6)) - 3);
                default: bx = int'($urandom_range(0, 1023));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                by = int'($urandom_range(0, 100));
            end else begin
                by = clamp10(BAR_Y - rad + int'($urandom_range(0, 6)) - 2);
            end
            apply_stimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                           bx, by, rad, barx);
        end
        reset = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_catch_referee.md
# ball_catch_referee

Game referee for the catch-the-ball game. It sits between the random ball-position generator and the display/score path. Each frame it compares the falling ball against the player's bar and emits the `caught` and `new_game` pulses the generator consumes. It also keeps score, remaining lives and the game state machine.

## Interface
Parameters:
- BAR_Y, 440: top edge (row) of the bar; collision line.
- BAR_W, 80: bar width in pixels.
- LIVES_INIT, 3: lives at game start (1..7).

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  debounced start button, level.
- frame_tick  in  1  one-cycle strobe per frame; all evaluation only on tick.
- ball_x  in  10  ball centre column.
- ball_y  in  10  ball centre row.
- radius  in  11  ball radius.
- bar_x  in  10  bar left edge column.
- caught  out  1  one-cycle pulse: ball landed on bar.
- new_game  out  1  one-cycle pulse: game (re)started.
- score  out  16  4-digit BCD score.
- lives  out  3  remaining lives.
- game_over  out  1  high in GAME_OVER state.
- speed_level  out  3  difficulty level (see Configuration).

## Operation
- States: IDLE, PLAY, GAME_OVER.
- IDLE → PLAY on `start`=1. The same edge pulses `new_game`, loads lives=LIVES_INIT, clears score, clears speed_level and sets armed=1.
- GAME_OVER → PLAY on `start`=1, with the same actions as from IDLE.
- `start` is ignored in PLAY.
- All comparisons use 12-bit zero-extended arithmetic; nothing wraps.
- bottom = ball_y + radius.
- in_x = (ball_x + radius >= bar_x) && (ball_x < bar_x + BAR_W + radius).
- In PLAY, on frame_tick with armed=1 and bottom >= BAR_Y:
  - in_x=1: pulse `caught`; score += 1 in BCD, saturating at 9999; clear armed.
  - in_x=0: miss. lives -= 1 and armed is cleared. If lives was 1, go to GAME_OVER.
- In PLAY, on frame_tick with bottom < BAR_Y: set armed=1 (ball has restarted at the top).
- Exactly one catch or miss is counted per fall.
- frame_tick outside PLAY has no effect.
- Reset dominates everything. Reset mid-game returns to IDLE with no `new_game` pulse.
- Reset values: state IDLE, caught 0, new_game 0, score 0x0000, lives 0, game_over 0, speed_level 0, armed 0.

## Timing
- All outputs are registered.
- `caught` and score update in the cycle after the frame_tick cycle in which the condition held.
- `new_game` goes high the cycle after `start` is sampled in IDLE or GAME_OVER. It is high for exactly 1 cycle even if `start` is held; a new press requires `start` to drop to 0 first (rising-edge detect, internal previous-start register, reset 0).
- Lives decrement and GAME_OVER entry are visible together, 1 cycle after the tick. `game_over` rises in that same cycle.
- `caught` and `new_game` are never high in the same cycle.
- `caught` pulses are separated by at least one re-arm tick.

## Configuration
- Macro `REFEREE_SPEED_LEVEL_EN`.
- Defined: speed_level increments every 8 catches (internal 3-bit catch counter wraps 7→0), saturating at 7. It is cleared on `new_game` and on reset. It updates in the same cycle as score.
- Undefined: speed_level is tied to 3'd0 and the catch counter is not built.

## Structure
- Shared package/include `game_pkg`:
  - state encoding (IDLE=2'd0, PLAY=2'd1, GAME_OVER=2'd2);
  - screen constants (H_RES 640, V_RES 480);
  - default BAR_Y and BAR_W, shared with the bar renderer and the ball generator.
- One sub-module, `bcd_counter4`: 4-digit BCD incrementer with enable, synchronous clear and saturation at 9999.
- FSM, collision compare, lives and speed logic stay in the top.

## Test plan
- Reset, then `start` pulse: new_game=1 for 1 cycle; lives=3, score=0000, state PLAY.
- Catch at left edge. Setup: bar_x=200, radius=10, ball_x=190, ball_y=430, tick. Result: caught=1 next cycle, score=0001. A further tick at ball_y=440 gives no second pulse. ball_y=20 with tick re-arms.
- Miss at right edge. Setup: bar_x=200, ball_x=290, radius=10, ball_y=430, tick. Result: caught=0, lives 3→2, score unchanged.
- Three misses in a row (re-arming between them): lives=0, game_over=1, state GAME_OVER. Further ticks cause no changes. `start` gives new_game, lives=3, score=0000.
- Force score to 9999 via catches, then one more catch: score stays 9999 and caught still pulses. With macro defined: speed_level=1 after 8 catches and 7 after 56 or more.
- Reset asserted in the same cycle as a qualifying tick: no caught pulse; all outputs at reset values next cycle. `start` held across reset release yields exactly one new_game.
